// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM stream reader: FSM encoding and default geometry.
package ram_stream_reader_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t DRAIN = 2'd2;

  localparam int C_DAT_W_DEF  = 8;
  localparam int C_ADR_W_DEF  = 10;
  localparam int C_LAT_DEF    = 2;
  localparam int C_FDEPTH_DEF = 4;

endpackage

// File: rtl/ram_stream_reader_fifo.sv
// Synchronous skid FIFO, power-of-two depth, with a flush input that wins over push/pop.
module ram_stream_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            din,
  input  logic                     pop,
  input  logic                     clear,
  output logic [DW-1:0]            dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Fetches LEN words from BASE upward out of a fixed-latency RAM read port and streams them
// on valid/ready; issue is credit-limited so the skid FIFO absorbs every in-flight word.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int C_DAT_W  = C_DAT_W_DEF,
  parameter int C_ADR_W  = C_ADR_W_DEF,
  parameter int C_LAT    = C_LAT_DEF,
  parameter int C_FDEPTH = C_FDEPTH_DEF
) (
  input  logic               CK_i,
  input  logic               XAR_i,
  input  logic               START_i,
  input  logic               ABORT_i,
  input  logic [C_ADR_W-1:0] BASEs_i,
  input  logic [C_ADR_W:0]   LENs_i,
  output logic [C_ADR_W-1:0] RAs_o,
  input  logic [C_DAT_W-1:0] RDs_i,
  output logic [C_DAT_W-1:0] Q_Ds_o,
  output logic               Q_VLD_o,
  input  logic               Q_RDY_i,
  output logic               BUSY_o,
  output logic               DONE_o
);

  localparam int CW = $clog2(C_FDEPTH) + 1;

  state_t             state;
  state_t             state_nxt;
  logic [C_ADR_W-1:0] base;
  logic [C_ADR_W:0]   len;
  logic [C_ADR_W:0]   issued;
  logic [C_ADR_W:0]   issued_inc;
  logic [C_LAT-1:0]   flight;
  logic [CW-1:0]      fifo_cnt;
  logic               fifo_empty;
  logic               pop;
  logic               push;
  logic               credit;
  logic               issue;
  logic               start_ok;
  logic               last_xfer;
  logic               done_nxt;

  assign issued_inc = issued + (C_ADR_W + 1)'(1);
  assign pop        = Q_VLD_o && Q_RDY_i;
  assign push       = flight[C_LAT-1];
  assign Q_VLD_o    = !fifo_empty;
  // A word leaving this cycle is still counted: credit only frees up after the pop lands.
  assign credit     = (int'(fifo_cnt) + $countones(flight)) < C_FDEPTH;
  assign last_xfer  = (flight == '0) && (fifo_cnt == CW'(1)) && pop;

  always_ff @(posedge CK_i or negedge XAR_i) begin
    if (!XAR_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (ABORT_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (START_i && (LENs_i != '0)) state_nxt = RUN;
        RUN:     if (issue && (issued_inc == len)) state_nxt = DRAIN;
        DRAIN:   if (last_xfer) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    BUSY_o   = 1'b0;
    issue    = 1'b0;
    start_ok = 1'b0;
    done_nxt = 1'b0;
    case (state)
      IDLE: begin
        start_ok = START_i && !ABORT_i;
        done_nxt = start_ok && (LENs_i == '0);
      end
      RUN: begin
        BUSY_o = 1'b1;
        issue  = credit && !ABORT_i;
      end
      DRAIN: begin
        BUSY_o   = 1'b1;
        done_nxt = last_xfer && !ABORT_i;
      end
      default: ;
    endcase
  end

  // flight[k] marks an address issued k+1 edges ago; the top bit lines up with its RDs_i word.
  always_ff @(posedge CK_i or negedge XAR_i) begin
    if (!XAR_i) begin
      base   <= '0;
      len    <= '0;
      issued <= '0;
      RAs_o  <= '0;
      flight <= '0;
      DONE_o <= 1'b0;
    end else begin
      DONE_o <= done_nxt;
      flight <= ABORT_i ? '0 : ((flight << 1) | C_LAT'(issue));
      if (start_ok) begin
        base   <= BASEs_i;
        len    <= LENs_i;
        issued <= '0;
      end else if (issue) begin
        RAs_o  <= base + issued[C_ADR_W-1:0];
        issued <= issued_inc;
      end
    end
  end

  ram_stream_fifo #(
    .DW    (C_DAT_W),
    .DEPTH (C_FDEPTH)
  ) u_fifo (
    .clk   (CK_i),
    .rst_n (XAR_i),
    .push  (push),
    .din   (RDs_i),
    .pop   (pop),
    .clear (ABORT_i),
    .dout  (Q_Ds_o),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: RAM preloaded with mem[a]=a[7:0], per-cycle model compare.
module tb_ram_stream_reader;

  logic       ck = 1'b0;
  logic       xar = 1'b0;
  logic       start = 1'b0;
  logic       abort_r = 1'b0;
  logic [9:0] base = '0;
  logic [10:0] len = '0;
  logic [9:0] ras;
  logic [7:0] rd;
  logic [7:0] q_d;
  logic       q_vld;
  logic       q_rdy = 1'b1;
  logic       busy;
  logic       done;

  int vectors = 0;
  int miscompares = 0;
  int rdy_mode = 0;

  logic [7:0] ram [1024];
  logic [7:0] dat_log [$];
  logic [9:0] ras_log [$];

  always #5 ck = ~ck;

  ram_stream_reader dut (
    .CK_i    (ck),
    .XAR_i   (xar),
    .START_i (start),
    .ABORT_i (abort_r),
    .BASEs_i (base),
    .LENs_i  (len),
    .RAs_o   (ras),
    .RDs_i   (rd),
    .Q_Ds_o  (q_d),
    .Q_VLD_o (q_vld),
    .Q_RDY_i (q_rdy),
    .BUSY_o  (busy),
    .DONE_o  (done)
  );

  // RAs_o is the RAM's address register; the RAM adds one output register.
  initial for (int i = 0; i < 1024; i++) ram[i] = 8'(i);
  always @(posedge ck) rd <= ram[ras];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : rdy_driver
    forever begin
      @(posedge ck);
      #1;
      case (rdy_mode)
        0:       q_rdy = 1'b1;
        1:       q_rdy = !q_rdy;
        2:       q_rdy = ($urandom_range(0, 3) != 0);
        default: q_rdy = 1'b0;
      endcase
    end
  end

  // Reference model: an idle/active flag plus the queue of words the job still owes.
  logic [7:0] exp_q [$];
  bit         active = 0;
  bit         done_exp = 0;
  bit         busy_exp = 0;
  bit         stall_prev = 0;
  logic [7:0] stall_dat = '0;
  logic [9:0] m_base = '0;
  logic [9:0] prev_ras = '0;
  int         m_len = 0;
  int         issue_idx = 0;

  initial begin : compare
    forever begin
      @(negedge ck);
      if (!xar) begin
        check("reset_ras", int'(ras), 0);
        check("reset_qd", int'(q_d), 0);
        check("reset_vld", int'(q_vld), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        exp_q.delete();
        active = 0; done_exp = 0; busy_exp = 0; stall_prev = 0; prev_ras = '0;
      end else begin
        check("done", int'(done), int'(done_exp));
        check("busy", int'(busy), int'(busy_exp));
        check("credit_over_depth", int'((int'(dut.fifo_cnt) + $countones(dut.flight)) > 4), 0);
        check("vld_without_pending_word", int'(q_vld && exp_q.size() == 0), 0);
        if (q_vld && exp_q.size() > 0) check("stream_data", int'(q_d), int'(exp_q[0]));
        if (stall_prev) begin
          check("stall_vld", int'(q_vld), 1);
          check("stall_data", int'(q_d), int'(stall_dat));
        end
        if (ras != prev_ras) begin
          ras_log.push_back(ras);
          if (active) begin
            if (issue_idx == 0 && prev_ras == m_base) issue_idx = 1;
            check("ras_sequence", int'(ras), (int'(m_base) + issue_idx) % 1024);
            issue_idx++;
          end else begin
            check("ras_moved_while_idle", int'(ras), int'(prev_ras));
          end
          prev_ras = ras;
        end
        stall_prev = q_vld && !q_rdy && !abort_r;
        stall_dat  = q_d;
        done_exp   = 0;
        if (abort_r) begin
          active = 0; busy_exp = 0; exp_q.delete();
        end else if (!active) begin
          if (start) begin
            if (len == 0) begin
              done_exp = 1;
            end else begin
              active = 1; busy_exp = 1;
              m_base = base; m_len = int'(len); issue_idx = 0;
              for (int i = 0; i < int'(len); i++) exp_q.push_back(8'((int'(base) + i) & 255));
            end
          end
        end else if (q_vld && q_rdy && exp_q.size() > 0) begin
          dat_log.push_back(q_d);
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            active = 0; busy_exp = 0; done_exp = 1;
            check("issue_count", issue_idx, m_len);
          end
        end
      end
    end
  end

  task automatic start_job(input logic [9:0] b, input logic [10:0] l);
    @(posedge ck);
    #1;
    start = 1'b1; base = b; len = l;
    @(posedge ck);
    #1;
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge ck);
    #1 abort_r = 1'b1;
    @(posedge ck);
    #1 abort_r = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge ck);
      n++;
    end
    check("done_within_budget", int'(done), 1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    logic [9:0]  b;
    logic [10:0] l;
    logic [9:0]  exp_ras [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    logic [7:0]  exp_dat [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    repeat (3) @(posedge ck);
    #3 xar = 1'b1;

    // Basic stream with first-word latency.
    rdy_mode = 0;
    dat_log.delete(); ras_log.delete();
    start_job(10'h010, 11'd8);
    n = 0;
    while (!q_vld && n < 20) begin
      @(negedge ck);
      n++;
    end
    check("t1_first_vld_latency", n, 4);
    check("t1_first_word", int'(q_d), 'h10);
    for (int i = 1; i < 8; i++) begin
      @(negedge ck);
      check("t1_back_to_back_vld", int'(q_vld), 1);
    end
    @(negedge ck);
    check("t1_done_after_last", int'(done), 1);
    check("t1_busy_low_with_done", int'(busy), 0);
    check("t1_word_count", dat_log.size(), 8);
    if (dat_log.size() == 8) check("t1_last_word", int'(dat_log[7]), 'h17);

    // Address wrap.
    dat_log.delete(); ras_log.delete();
    start_job(10'h3FE, 11'd4);
    wait_done(60);
    check("t2_ras_count", ras_log.size(), 4);
    check("t2_word_count", dat_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ras_log.size()) check("t2_ras", int'(ras_log[i]), int'(exp_ras[i]));
      if (i < dat_log.size()) check("t2_word", int'(dat_log[i]), int'(exp_dat[i]));
    end

    // Zero length: DONE only.
    ras_log.delete();
    start_job(10'h155, 11'd0);
    @(negedge ck);
    check("t4_done_pulse", int'(done), 1);
    check("t4_busy_stays_low", int'(busy), 0);
    @(negedge ck);
    check("t4_done_one_cycle", int'(done), 0);
    check("t4_no_reads", ras_log.size(), 0);

    // START and ABORT together in IDLE: abort wins.
    @(posedge ck);
    #1 start = 1'b1; abort_r = 1'b1; base = 10'h020; len = 11'd5;
    @(posedge ck);
    #1 start = 1'b0; abort_r = 1'b0;
    @(negedge ck);
    check("abort_beats_start_busy", int'(busy), 0);

    // Toggling ready, a long stall and a stray START while busy.
    dat_log.delete();
    rdy_mode = 1;
    start_job(10'h200, 11'd16);
    repeat (12) @(negedge ck);
    rdy_mode = 3;
    start_job(10'h000, 11'd5);
    repeat (8) @(negedge ck);
    rdy_mode = 0;
    wait_done(100);
    check("t3_word_count", dat_log.size(), 16);

    // Abort mid-job, then a clean short job.
    dat_log.delete();
    start_job(10'h040, 11'd32);
    n = 0;
    while (dat_log.size() < 5 && n < 100) begin
      @(negedge ck);
      n++;
    end
    check("t5_reached_five_words", int'(dat_log.size() >= 5), 1);
    pulse_abort();
    @(negedge ck);
    check("t5_vld_after_abort", int'(q_vld), 0);
    check("t5_busy_after_abort", int'(busy), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge ck);
      check("t5_no_done_after_abort", int'(done), 0);
    end
    dat_log.delete();
    start_job(10'h100, 11'd2);
    wait_done(40);
    check("t5_word_count", dat_log.size(), 2);
    if (dat_log.size() == 2) begin
      check("t5_word0", int'(dat_log[0]), 'h00);
      check("t5_word1", int'(dat_log[1]), 'h01);
    end

    // Asynchronous reset mid-run.
    start_job(10'h080, 11'd20);
    repeat (6) @(negedge ck);
    #2 xar = 1'b0;
    #1;
    check("t6_async_ras", int'(ras), 0);
    check("t6_async_qd", int'(q_d), 0);
    check("t6_async_vld", int'(q_vld), 0);
    check("t6_async_busy", int'(busy), 0);
    check("t6_async_done", int'(done), 0);
    repeat (3) @(posedge ck);
    #3 xar = 1'b1;
    dat_log.delete();
    start_job(10'h000, 11'd3);
    wait_done(40);
    check("t6_word_count", dat_log.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < dat_log.size()) check("t6_word", int'(dat_log[i]), i);
    end

    // Randomized jobs, random ready, occasional aborts; the last one reads the whole RAM.
    rdy_mode = 2;
    for (int j = 0; j < 24; j++) begin
      do b = 10'($urandom_range(0, 1023)); while (b == ras);
      l = (j == 23) ? 11'd1024 : 11'($urandom_range(1, 40));
      start_job(b, l);
      if (j != 23 && $urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 30)) @(posedge ck);
        pulse_abort();
        repeat (2) @(posedge ck);
      end else begin
        if (l >= 11'd10) begin
          @(posedge ck);
          #1 start = 1'b1; base = ~b; len = 11'd3;
          @(posedge ck);
          #1 start = 1'b0;
        end
        wait_done(int'(l) * 4 + 60);
      end
    end

    repeat (5) @(posedge ck);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
